lpc_io_host: RTL and testbench
==============================

// Module: lpc_io_host
// PURPOSE
// - LPC I/O-cycle initiator: the host side of the LPC target register file. Turns single-byte
//   read/write requests from local logic into LPC I/O frames on LAD[3:0]/LFRAME#.
// - Sits between the board-management bus logic and the LPC pins; used for FPGA-to-FPGA
//   register access and for bench loopback against the target register block.
// PARAMETERS
// - SYNC_TIMEOUT  8     clocks in SYNC with no valid SYNC code before abort (no responder)
// - LWAIT_MAX     1024  max consecutive long-wait (0110) SYNC clocks before abort
// - ABORT_CLKS    4     clocks LFRAME# held low with LAD=1111 during abort
// PORTS
// - LpcClock   in   1   33 MHz LPC clock; all logic on rising edge
// - PciReset   in   1   reset, synchronous, active-high
// - ReqValid   in   1   request present
// - ReqReady   out  1   request accepted when ReqValid & ReqReady
// - ReqWr      in   1   1 = I/O write, 0 = I/O read
// - ReqAddr    in   16  I/O address
// - ReqData    in   8   write data
// - RspValid   out  1   one-clock pulse: transaction finished
// - RspData    out  8   read data, valid with RspValid (0x00 for writes / errors)
// - RspErr     out  2   00 ok, 01 timeout abort, 10 SYNC error (1010), 11 long-wait overrun
// - LFrameN    out  1   LFRAME#, active low
// - LadOut     out  4   LAD drive value
// - LadOe      out  1   LAD output enable
// - LadIn      in   4   LAD sampled value
// - Busy       out  1   high whenever state != IDLE
// BEHAVIOUR
// - Reset (sync, high): state IDLE, LFrameN=1, LadOut=4'hF, LadOe=0, ReqReady=0 during reset,
//   RspValid=0, RspData=0, RspErr=0, Busy=0, all counters 0. Mid-frame reset: pins released
//   next edge, request dropped, no RspValid.
// - ReqReady = (state==IDLE) & !PciReset. Request fields captured on accept edge.
// - FSM per clock, LadOe=1 unless noted:
//   IDLE -> START: LFrameN=0, LAD=0000 (1 clk)
//   CYCT: LAD=0010 write / 0000 read (1 clk)
//   ADDR: 4 clks, nibbles A[15:12],A[11:8],A[7:4],A[3:0]
//   WDATA (write only): 2 clks, D[3:0] then D[7:4]
//   HTAR: clk1 LAD=1111 driven, clk2 LadOe=0
//   SYNC: LadOe=0, sample LadIn each clk:
//     0000 ready -> RDATA (read) or PTAR (write); 0101 short wait -> stay;
//     0110 long wait -> stay, LWAIT counter++; 1010 -> PTAR with err=10;
//     any other code counts toward SYNC_TIMEOUT (counter reset on 0101/0110).
//     Timeout counter reaching SYNC_TIMEOUT -> ABORT err=01; LWAIT counter reaching
//     LWAIT_MAX -> ABORT err=11.
//   RDATA: 2 clks LadOe=0, capture D[3:0] then D[7:4]
//   PTAR: 2 clks LadOe=0 (peripheral turnaround)
//   ABORT: LFrameN=0, LAD=1111 for ABORT_CLKS, then 1 clk LFrameN=1, LadOe=0
//   -> DONE: RspValid=1 for 1 clk with RspData/RspErr, -> IDLE; LadOe=0 in IDLE
// - Min latency accept->RspValid: 14 clks (read or write, SYNC ready on first SYNC clk).
// - Back-to-back: new request accepted in the IDLE cycle after DONE (one idle clk between frames).
// - RspData/RspErr hold value until next RspValid.
// - LFrameN low only in START and ABORT; never low with LadOe=0.
// STRUCTURE
// - Package lpc_pkg: state enum (IDLE,START,CYCT,ADDR,WDATA,HTAR,SYNC,RDATA,PTAR,ABORT,DONE),
//   LAD nibble constants (START=0000, CYC_IO_RD=0000, CYC_IO_WR=0010, SYNC_READY=0000,
//   SYNC_SHORT=0101, SYNC_LONG=0110, SYNC_ERR=1010), RspErr codes.
// - One sub-module: lpc_sync_timer (timeout + long-wait counters, clear/inc/expire flags).
// TESTING
// - Write 0x0080<-0xA5, SYNC ready on first SYNC clk -> LAD 0000,0010,0,0,8,0,5,A,F,Z;
//   RspValid at clk 14, RspErr=00.
// - Read 0x0300, responder 2x 0101 then 0000, data 3,C -> RspData=0xC3, RspErr=00, latency 16.
// - No responder (LadIn=1111 floating) -> ABORT after 8 SYNC clks, LFrameN low 4 clks
//   LAD=1111, RspErr=01, RspData=00.
// - Responder returns 1010 on read -> no data phase, 2 PTAR clks, RspErr=10.
// - Continuous 0110 with LWAIT_MAX=16 -> abort after 16 long-wait clks, RspErr=11.
// - PciReset asserted during ADDR phase -> next edge LFrameN=1, LadOe=0, Busy=0, no RspValid;
//   following request completes normally.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared types and LAD encodings for the LPC I/O-cycle host.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_CYCT  = 4'd2,
    ST_ADDR  = 4'd3,
    ST_WDATA = 4'd4,
    ST_HTAR  = 4'd5,
    ST_SYNC  = 4'd6,
    ST_RDATA = 4'd7,
    ST_PTAR  = 4'd8,
    ST_ABORT = 4'd9,
    ST_DONE  = 4'd10
  } lpc_state_e;

  // LAD nibble codes
  localparam logic [3:0] LAD_START      = 4'b0000;
  localparam logic [3:0] LAD_CYC_IO_RD  = 4'b0000;
  localparam logic [3:0] LAD_CYC_IO_WR  = 4'b0010;
  localparam logic [3:0] LAD_SYNC_READY = 4'b0000;
  localparam logic [3:0] LAD_SYNC_SHORT = 4'b0101;
  localparam logic [3:0] LAD_SYNC_LONG  = 4'b0110;
  localparam logic [3:0] LAD_SYNC_ERR   = 4'b1010;
  localparam logic [3:0] LAD_IDLE       = 4'b1111;

  // Response error codes
  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_TIMEOUT = 2'b01;
  localparam logic [1:0] RSP_SYNCERR = 2'b10;
  localparam logic [1:0] RSP_LWAIT   = 2'b11;

  // True for the SYNC codes that do not count toward the no-responder timeout
  function automatic logic sync_is_known(input logic [3:0] code);
    return (code == LAD_SYNC_READY) || (code == LAD_SYNC_SHORT) ||
           (code == LAD_SYNC_LONG)  || (code == LAD_SYNC_ERR);
  endfunction

endpackage

// File: rtl/lpc_sync_timer.sv
// SYNC-phase watchdogs: no-responder timeout and consecutive long-wait limit.
// Expire flags are combinational so the FSM can leave SYNC on the very clock
// the limit is reached.
module lpc_sync_timer #(
  parameter int SYNC_TIMEOUT = 8,
  parameter int LWAIT_MAX    = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,        // hold both counters at zero (outside SYNC)
  input  logic i_to_inc,     // unrecognised SYNC code this clock
  input  logic i_to_rst,     // short/long wait seen: responder is alive
  input  logic i_lw_inc,     // long-wait code this clock
  input  logic i_lw_rst,     // anything but long-wait breaks the run
  output logic o_to_expire,
  output logic o_lw_expire
);

  localparam int TO_W = $clog2(SYNC_TIMEOUT + 1);
  localparam int LW_W = $clog2(LWAIT_MAX + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYNC_TIMEOUT - 1);
  localparam logic [LW_W-1:0] LW_LAST = LW_W'(LWAIT_MAX - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic [LW_W-1:0] r_lw_cnt;

  // Counter update; clear has priority over increment
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_to_cnt <= '0;
      r_lw_cnt <= '0;
    end else begin
      if (i_to_rst)      r_to_cnt <= '0;
      else if (i_to_inc) r_to_cnt <= r_to_cnt + 1'b1;
      if (i_lw_inc)      r_lw_cnt <= r_lw_cnt + 1'b1;
      else if (i_lw_rst) r_lw_cnt <= '0;
    end
  end

  assign o_to_expire = i_to_inc && (r_to_cnt == TO_LAST);
  assign o_lw_expire = i_lw_inc && (r_lw_cnt == LW_LAST);

endmodule

// File: rtl/lpc_io_host.sv
// LPC I/O-cycle initiator: single-byte read/write requests to LAD/LFRAME# frames.
module lpc_io_host
  import lpc_pkg::*;
#(
  parameter int SYNC_TIMEOUT = 8,
  parameter int LWAIT_MAX    = 1024,
  parameter int ABORT_CLKS   = 4
) (
  input  logic        i_LpcClock,
  input  logic        i_PciReset,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWr,
  input  logic [15:0] i_ReqAddr,
  input  logic [7:0]  i_ReqData,
  output logic        o_RspValid,
  output logic [7:0]  o_RspData,
  output logic [1:0]  o_RspErr,
  output logic        o_LFrameN,
  output logic [3:0]  o_LadOut,
  output logic        o_LadOe,
  input  logic [3:0]  i_LadIn,
  output logic        o_Busy
);

  lpc_state_e r_state, w_next;

  logic        r_wr;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [1:0]  r_err;
  logic [7:0]  r_cnt;       // clocks spent in the current state
  logic [7:0]  r_rsp_data;
  logic [1:0]  r_rsp_err;

  logic w_accept;
  logic w_in_sync;
  logic w_is_long, w_is_short, w_is_err, w_is_ready, w_is_other;
  logic w_to_expire, w_lw_expire;

  assign o_ReqReady = (r_state == ST_IDLE) && !i_PciReset;
  assign w_accept   = i_ReqValid && o_ReqReady;
  assign o_Busy     = (r_state != ST_IDLE);
  assign o_RspValid = (r_state == ST_DONE);
  assign o_RspData  = r_rsp_data;
  assign o_RspErr   = r_rsp_err;

  // SYNC code decode
  assign w_in_sync  = (r_state == ST_SYNC);
  assign w_is_ready = (i_LadIn == LAD_SYNC_READY);
  assign w_is_short = (i_LadIn == LAD_SYNC_SHORT);
  assign w_is_long  = (i_LadIn == LAD_SYNC_LONG);
  assign w_is_err   = (i_LadIn == LAD_SYNC_ERR);
  assign w_is_other = !sync_is_known(i_LadIn);

  lpc_sync_timer #(
    .SYNC_TIMEOUT (SYNC_TIMEOUT),
    .LWAIT_MAX    (LWAIT_MAX)
  ) u_timer (
    .i_clk       (i_LpcClock),
    .i_rst       (i_PciReset),
    .i_clr       (!w_in_sync),
    .i_to_inc    (w_in_sync && w_is_other),
    .i_to_rst    (w_in_sync && (w_is_short || w_is_long)),
    .i_lw_inc    (w_in_sync && w_is_long),
    .i_lw_rst    (w_in_sync && !w_is_long),
    .o_to_expire (w_to_expire),
    .o_lw_expire (w_lw_expire)
  );

  // State register
  always_ff @(posedge i_LpcClock) begin
    if (i_PciReset) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_START;
      ST_START: w_next = ST_CYCT;
      ST_CYCT:  w_next = ST_ADDR;
      ST_ADDR:  if (r_cnt == 8'd3) w_next = r_wr ? ST_WDATA : ST_HTAR;
      ST_WDATA: if (r_cnt == 8'd1) w_next = ST_HTAR;
      ST_HTAR:  if (r_cnt == 8'd1) w_next = ST_SYNC;
      ST_SYNC: begin
        if (w_is_ready)                    w_next = r_wr ? ST_PTAR : ST_RDATA;
        else if (w_is_err)                 w_next = ST_PTAR;
        else if (w_is_long && w_lw_expire) w_next = ST_ABORT;
        else if (w_to_expire)              w_next = ST_ABORT;
      end
      ST_RDATA: if (r_cnt == 8'd1) w_next = ST_PTAR;
      ST_PTAR:  if (r_cnt == 8'd1) w_next = ST_DONE;
      ST_ABORT: if (r_cnt == 8'(ABORT_CLKS)) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Pin outputs per state; LAD is released everywhere not listed
  always_comb begin
    o_LFrameN = 1'b1;
    o_LadOut  = LAD_IDLE;
    o_LadOe   = 1'b0;
    case (r_state)
      ST_START: begin
        o_LFrameN = 1'b0;
        o_LadOut  = LAD_START;
        o_LadOe   = 1'b1;
      end
      ST_CYCT: begin
        o_LadOut = r_wr ? LAD_CYC_IO_WR : LAD_CYC_IO_RD;
        o_LadOe  = 1'b1;
      end
      ST_ADDR: begin
        o_LadOe = 1'b1;
        case (r_cnt[1:0])
          2'd0:    o_LadOut = r_addr[15:12];
          2'd1:    o_LadOut = r_addr[11:8];
          2'd2:    o_LadOut = r_addr[7:4];
          default: o_LadOut = r_addr[3:0];
        endcase
      end
      ST_WDATA: begin
        o_LadOe  = 1'b1;
        o_LadOut = (r_cnt == 8'd0) ? r_wdata[3:0] : r_wdata[7:4];
      end
      // first turnaround clock drives 1111, second releases the bus
      ST_HTAR:  o_LadOe = (r_cnt == 8'd0);
      ST_ABORT: begin
        if (r_cnt < 8'(ABORT_CLKS)) begin
          o_LFrameN = 1'b0;
          o_LadOe   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Request capture, phase counter, SYNC outcome and response registers
  always_ff @(posedge i_LpcClock) begin
    if (i_PciReset) begin
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= RSP_OK;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= RSP_OK;
    end else begin
      r_cnt <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
      if (w_accept) begin
        r_wr    <= i_ReqWr;
        r_addr  <= i_ReqAddr;
        r_wdata <= i_ReqData;
        r_rdata <= '0;
        r_err   <= RSP_OK;
      end
      if (w_in_sync) begin
        if (w_is_err)                      r_err <= RSP_SYNCERR;
        else if (w_is_long && w_lw_expire) r_err <= RSP_LWAIT;
        else if (w_to_expire)              r_err <= RSP_TIMEOUT;
      end
      if (r_state == ST_RDATA) begin
        if (r_cnt == 8'd0) r_rdata[3:0] <= i_LadIn;
        else               r_rdata[7:4] <= i_LadIn;
      end
      // response fields only change when a new response is presented
      if (w_next == ST_DONE && r_state != ST_DONE) begin
        r_rsp_err  <= r_err;
        r_rsp_data <= (r_wr || r_err != RSP_OK) ? 8'h00 : r_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lpc_io_host.sv
// Bench for lpc_io_host: scripted LPC responder plus a frame-level reference model.
module tb_lpc_io_host;

  localparam int TO = 8;
  localparam int LW = 16;
  localparam int AB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  logic        req_ready, rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_err;
  logic        lframe_n, lad_oe, busy;
  logic [3:0]  lad_out, lad_in;

  lpc_io_host #(.SYNC_TIMEOUT(TO), .LWAIT_MAX(LW), .ABORT_CLKS(AB)) dut (
    .i_LpcClock (clk),
    .i_PciReset (rst),
    .i_ReqValid (req_valid),
    .o_ReqReady (req_ready),
    .i_ReqWr    (req_wr),
    .i_ReqAddr  (req_addr),
    .i_ReqData  (req_data),
    .o_RspValid (rsp_valid),
    .o_RspData  (rsp_data),
    .o_RspErr   (rsp_err),
    .o_LFrameN  (lframe_n),
    .o_LadOut   (lad_out),
    .o_LadOe    (lad_oe),
    .i_LadIn    (lad_in),
    .o_Busy     (busy)
  );

  always #15 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] prev_data;
  logic [1:0] prev_err;

  // responder script: SYNC codes in order; once exhausted the bus floats (1111)
  logic [3:0] scr_q[$];
  // expected per-clock pins {LFrameN, LadOe, LAD} from START onward, and LadIn to drive
  logic [5:0] exp_q[$];
  logic [3:0] din_q[$];
  logic [7:0] m_data;
  logic [1:0] m_err;

  function automatic void push(input logic lf, input logic oe, input logic [3:0] lad,
                               input logic [3:0] din);
    exp_q.push_back({lf, oe, lad});
    din_q.push_back(din);
  endfunction

  // Frame-level model: header, turnaround, SYNC outcome, then data/turnaround or abort
  function automatic void build_model(input logic wr, input logic [15:0] addr,
                                      input logic [7:0] data, input logic [7:0] rdat);
    int to_n, lw_n, i;
    logic [3:0] c;
    logic done;
    exp_q.delete();
    din_q.delete();
    push(1'b0, 1'b1, 4'h0, 4'hF);
    push(1'b1, 1'b1, wr ? 4'h2 : 4'h0, 4'hF);
    for (int n = 3; n >= 0; n--) push(1'b1, 1'b1, addr[n*4 +: 4], 4'hF);
    if (wr) begin
      push(1'b1, 1'b1, data[3:0], 4'hF);
      push(1'b1, 1'b1, data[7:4], 4'hF);
    end
    push(1'b1, 1'b1, 4'hF, 4'hF);
    push(1'b1, 1'b0, 4'hF, 4'hF);
    to_n = 0; lw_n = 0; i = 0; done = 1'b0;
    m_data = 8'h00; m_err = 2'b00;
    while (!done && i < 4000) begin
      c = (i < scr_q.size()) ? scr_q[i] : 4'hF;
      i++;
      push(1'b1, 1'b0, 4'hF, c);
      if (c == 4'h0) begin
        done = 1'b1;
        if (!wr) begin
          push(1'b1, 1'b0, 4'hF, rdat[3:0]);
          push(1'b1, 1'b0, 4'hF, rdat[7:4]);
          m_data = rdat;
        end
        push(1'b1, 1'b0, 4'hF, 4'hF);
        push(1'b1, 1'b0, 4'hF, 4'hF);
      end else if (c == 4'hA) begin
        done = 1'b1;
        m_err = 2'b10;
        push(1'b1, 1'b0, 4'hF, 4'hF);
        push(1'b1, 1'b0, 4'hF, 4'hF);
      end else begin
        if (c == 4'h5) begin
          to_n = 0; lw_n = 0;
        end else if (c == 4'h6) begin
          to_n = 0; lw_n++;
          if (lw_n == LW) begin done = 1'b1; m_err = 2'b11; end
        end else begin
          to_n++; lw_n = 0;
          if (to_n == TO) begin done = 1'b1; m_err = 2'b01; end
        end
        if (done) begin
          for (int a = 0; a < AB; a++) push(1'b0, 1'b1, 4'hF, 4'hF);
          push(1'b1, 1'b0, 4'hF, 4'hF);
        end
      end
    end
  endfunction

  // One complete transaction starting from an IDLE cycle, checked clock by clock
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                         input logic [7:0] rdat, input string name);
    logic [7:0] obs, expv;
    logic [5:0] e;
    build_model(wr, addr, data, rdat);
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, req_ready, rsp_data, rsp_err} !== {1'b0, 1'b0, 1'b1, prev_data, prev_err}) begin
      errors++;
      $display("FAIL %s idle: rv/busy/rdy/data/err got %b %b %b %h %b want 0 0 1 %h %b",
               name, rsp_valid, busy, req_ready, rsp_data, rsp_err, prev_data, prev_err);
    end
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = data; lad_in = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wr = 1'($urandom); req_addr = 16'($urandom); req_data = 8'($urandom);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      lad_in = din_q[k];
      e = exp_q[k];
      obs  = {lframe_n, lad_oe, lad_oe ? lad_out : 4'h0, rsp_valid, busy};
      expv = {e[5], e[4], e[4] ? e[3:0] : 4'h0, 1'b0, 1'b1};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s clk%0d: {lf,oe,lad,rv,busy} got %b want %b", name, k + 1, obs, expv);
      end
    end
    @(negedge clk);
    lad_in = 4'hF;
    checks++;
    if ({rsp_valid, busy, rsp_data, rsp_err} !== {1'b1, 1'b1, m_data, m_err}) begin
      errors++;
      $display("FAIL %s rsp clk%0d: rv/busy/data/err got %b %b %h %b want 1 1 %h %b",
               name, exp_q.size() + 1, rsp_valid, busy, rsp_data, rsp_err, m_data, m_err);
    end
    prev_data = m_data;
    prev_err  = m_err;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0; lad_in = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({lframe_n, lad_out, lad_oe, req_ready, rsp_valid, rsp_data, rsp_err, busy} !==
        {1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset: lf/lad/oe/rdy/rv/data/err/busy got %b %h %b %b %b %h %b %b",
               lframe_n, lad_out, lad_oe, req_ready, rsp_valid, rsp_data, rsp_err, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ReqReady got %b want 1", req_ready);
    end
    prev_data = 8'h00;
    prev_err  = 2'b00;
  endtask

  task automatic test_write_basic();
    scr_q = '{4'h0};
    run_txn(1'b1, 16'h0080, 8'hA5, 8'h00, "write_0080");
  endtask

  task automatic test_read_wait();
    scr_q = '{4'h5, 4'h5, 4'h0};
    run_txn(1'b0, 16'h0300, 8'h00, 8'hC3, "read_0300");
  endtask

  task automatic test_no_responder();
    scr_q.delete();
    run_txn(1'b0, 16'h1234, 8'h00, 8'h5A, "no_resp");
  endtask

  task automatic test_sync_err();
    scr_q = '{4'hA};
    run_txn(1'b0, 16'hBEEF, 8'h00, 8'h77, "sync_err");
  endtask

  task automatic test_long_wait();
    scr_q.delete();
    for (int i = 0; i < LW + 4; i++) scr_q.push_back(4'h6);
    run_txn(1'b1, 16'h4321, 8'h3C, 8'h00, "lwait");
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'hCAFE; req_data = 8'h11; lad_in = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, lframe_n, lad_oe} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_addr: busy/lf/oe got %b%b%b want 111", busy, lframe_n, lad_oe);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({lframe_n, lad_oe, busy, rsp_valid, req_ready} !== 5'b10000) begin
      errors++;
      $display("FAIL midrst_release: lf/oe/busy/rv/rdy got %b%b%b%b%b want 10000",
               lframe_n, lad_oe, busy, rsp_valid, req_ready);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL midrst_quiet clk%0d: rv/busy got %b%b want 00", k, rsp_valid, busy);
      end
    end
    prev_data = 8'h00;
    prev_err  = 2'b00;
    scr_q = '{4'h5, 4'h0};
    run_txn(1'b0, 16'h0061, 8'h00, 8'h9D, "after_rst");
  endtask

  task automatic test_random();
    logic [3:0] bad[12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    int nw, term;
    for (int t = 0; t < 24; t++) begin
      scr_q.delete();
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) scr_q.push_back($urandom_range(0, 1) ? 4'h5 : 4'h6);
      term = $urandom_range(0, 9);
      if (term <= 6)      scr_q.push_back(4'h0);
      else if (term == 7) scr_q.push_back(4'hA);
      else if (term == 8) scr_q.push_back(bad[$urandom_range(0, 11)]);
      run_txn(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), $sformatf("rand%0d", t));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_no_responder();
    test_sync_err();
    test_long_wait();
    test_mid_reset();
    test_random();
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, rsp_data, rsp_err} !== {1'b0, 1'b0, prev_data, prev_err}) begin
      errors++;
      $display("FAIL final_hold: rv/busy/data/err got %b %b %h %b want 0 0 %h %b",
               rsp_valid, busy, rsp_data, rsp_err, prev_data, prev_err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
